// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift register: shift modes, FSM states
// and the per-bit cell select.
package shift_pkg;

   typedef enum logic [1:0] {
      MODE_LSR = 2'b00,
      MODE_ASR = 2'b01,
      MODE_LSL = 2'b10,
      MODE_ROR = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   // "Left" is the neighbour toward the MSB, "right" the one toward the LSB.
   typedef enum logic [1:0] {
      SEL_HOLD  = 2'b00,
      SEL_LOAD  = 2'b01,
      SEL_LEFT  = 2'b10,
      SEL_RIGHT = 2'b11
   } sel_e;

endpackage

// File: rtl/sr_cell.sv
// One bit of the shift register: a 4-way select feeding a flop with
// synchronous clear.
module sr_cell
   import shift_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  sel_e sel,
   input  logic load_d,
   input  logic left_d,
   input  logic right_d,
   output logic q
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      case (sel)
         SEL_LOAD:  q_d = load_d;
         SEL_LEFT:  q_d = left_d;
         SEL_RIGHT: q_d = right_d;
         default:   q_d = q_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/shift_seq_reg.sv
// Multi-cycle shift register: loads in parallel, then performs one shift step
// per clock for a captured amount and mode, pulsing done at the end.
module shift_seq_reg
   import shift_pkg::*;
#(
   parameter  int N  = 16,
   localparam int AW = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          ld,
   input  logic [N-1:0]  in,
   input  logic          start,
   input  logic [AW-1:0] amt,
   input  logic [1:0]    mode,
   input  logic          sin,
   output logic [N-1:0]  out,
   output logic          sout,
   output logic          busy,
   output logic          done
);

   state_e        state_q, state_d;
   mode_e         mode_q, mode_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          sout_q, sout_d;
   sel_e          sel;
   logic          fill_hi;
   logic [N-1:0]  cell_q;

   // Bit entering at the MSB on right-going modes.
   always_comb begin
      fill_hi = sin;
      case (mode_q)
         MODE_ASR: fill_hi = cell_q[N-1];
         MODE_ROR: fill_hi = cell_q[0];
         default:  fill_hi = sin;
      endcase
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      sout_d  = sout_q;
      sel     = SEL_HOLD;
      case (state_q)
         ST_IDLE: begin
            if (ld) begin
               sel = SEL_LOAD;
            end else if (start) begin
               mode_d  = mode_e'(mode);
               cnt_d   = amt;
               state_d = (amt == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sel    = (mode_q == MODE_LSL) ? SEL_RIGHT : SEL_LEFT;
            sout_d = (mode_q == MODE_LSL) ? cell_q[N-1] : cell_q[0];
            cnt_d  = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_LSR;
         cnt_q   <= '0;
         sout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         sout_q  <= sout_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cell
         logic left_in;
         logic right_in;
         if (gi == N - 1) begin : g_msb
            assign left_in = fill_hi;
         end else begin : g_mid_l
            assign left_in = cell_q[gi+1];
         end
         if (gi == 0) begin : g_lsb
            assign right_in = sin;
         end else begin : g_mid_r
            assign right_in = cell_q[gi-1];
         end
         sr_cell u_cell (
            .clk     (clk),
            .clr     (clr),
            .sel     (sel),
            .load_d  (in[gi]),
            .left_d  (left_in),
            .right_d (right_in),
            .q       (cell_q[gi])
         );
      end
   endgenerate

   assign out  = cell_q;
   assign sout = sout_q;
   assign busy = (state_q == ST_SHIFT);
   assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_seq_reg.sv
// Directed plus randomized bench for shift_seq_reg with N=16, checked against
// an arithmetic reference model of each shift step.
module tb_shift_seq_reg;

   localparam int N  = 16;
   localparam int AW = $clog2(N) + 1;

   logic          clk = 1'b0;
   logic          clr = 1'b0;
   logic          ld = 1'b0;
   logic [N-1:0]  din = '0;
   logic          start = 1'b0;
   logic [AW-1:0] amt = '0;
   logic [1:0]    mode = 2'b00;
   logic          sin = 1'b0;
   logic [N-1:0]  out;
   logic          sout;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   logic [N-1:0] ref_out  = '0;
   logic         ref_sout = 1'b0;

   shift_seq_reg #(.N(N)) dut (
      .clk   (clk),
      .clr   (clr),
      .ld    (ld),
      .in    (din),
      .start (start),
      .amt   (amt),
      .mode  (mode),
      .sin   (sin),
      .out   (out),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One shift step computed arithmetically from the mode rules.
   task automatic model_step(input logic [1:0] m, input logic s);
      logic [N-1:0] v;
      v = ref_out;
      case (m)
         2'b00: begin ref_sout = v[0];   ref_out = (v >> 1) | ({{(N-1){1'b0}}, s} << (N-1)); end
         2'b01: begin ref_sout = v[0];   ref_out = N'($signed(v) >>> 1); end
         2'b10: begin ref_sout = v[N-1]; ref_out = (v << 1) | {{(N-1){1'b0}}, s}; end
         default: begin ref_sout = v[0]; ref_out = (v >> 1) | (v << (N-1)); end
      endcase
   endtask

   // fsin < 0 means randomize sin every step; otherwise hold it at fsin.
   task automatic do_op(input logic [N-1:0] val, input logic [1:0] m, input int a, input int fsin);
      ld    = 1'b1;
      din   = val;
      start = 1'($urandom_range(0, 1));
      tick();
      ref_out = val;
      chk("load_out", out, val);
      chk("load_busy", busy, 0);
      chk("load_done", done, 0);
      ld    = 1'b0;
      start = 1'b1;
      mode  = m;
      amt   = AW'(a);
      tick();
      start = 1'b0;
      if (a == 0) begin
         chk("amt0_done", done, 1);
         chk("amt0_busy", busy, 0);
         chk("amt0_out", out, ref_out);
         chk("amt0_sout", sout, ref_sout);
      end else begin
         chk("start_busy", busy, 1);
         chk("start_out", out, ref_out);
         for (int s = 1; s <= a; s++) begin
            sin   = (fsin < 0) ? 1'($urandom_range(0, 1)) : 1'(fsin);
            din   = N'($urandom);
            amt   = AW'($urandom);
            mode  = 2'($urandom);
            ld    = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            tick();
            model_step(m, sin);
            chk($sformatf("step%0d_out", s), out, ref_out);
            chk($sformatf("step%0d_sout", s), sout, ref_sout);
            chk($sformatf("step%0d_busy", s), busy, (s < a) ? 1 : 0);
            chk($sformatf("step%0d_done", s), done, (s < a) ? 0 : 1);
         end
      end
      ld    = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      din   = N'($urandom);
      tick();
      ld    = 1'b0;
      start = 1'b0;
      chk("ret_done", done, 0);
      chk("ret_busy", busy, 0);
      chk("ret_out", out, ref_out);
   endtask

   initial begin
      clr = 1'b1;
      ld  = 1'b1;
      din = 16'hFFFF;
      start = 1'b1;
      tick();
      clr = 1'b0; ld = 1'b0; start = 1'b0;
      chk("rst_out", out, 0);
      chk("rst_sout", sout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      ld = 1'b1; din = 16'hA5C3;
      tick();
      ld = 1'b0;
      chk("ld_a5c3", out, 16'hA5C3);
      chk("ld_busy", busy, 0);
      chk("ld_done", done, 0);
      ref_out = 16'hA5C3;

      do_op(16'h8001, 2'b01, 4, 0);
      chk("asr_final", out, 16'hF800);
      chk("asr_sout", sout, 0);

      do_op(16'h0001, 2'b10, 3, 1);
      chk("lsl_final", out, 16'h000F);
      chk("lsl_sout", sout, 0);

      do_op(16'h1234, 2'b11, 16, -1);
      chk("ror_final", out, 16'h1234);
      chk("ror_sout", sout, 0);

      do_op(16'h5A5A, 2'b00, 0, 0);
      chk("amt0_final", out, 16'h5A5A);

      ld = 1'b1; start = 1'b1; din = 16'h0F0F; amt = AW'(3);
      tick();
      ld = 1'b0; start = 1'b0;
      chk("ldwin_out", out, 16'h0F0F);
      chk("ldwin_busy", busy, 0);
      tick();
      chk("ldwin_nodone", done, 0);
      ref_out = 16'h0F0F;

      do_op(16'hC001, 2'b00, 20, 1);
      chk("lsr_allfill", out, 16'hFFFF);
      do_op(16'h8000, 2'b01, 17, 0);
      chk("asr_allsign", out, 16'hFFFF);

      ld = 1'b1; din = 16'hBEEF;
      tick();
      ld = 1'b0; start = 1'b1; mode = 2'b00; amt = AW'(5);
      tick();
      start = 1'b0;
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("abort_out", out, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      tick();
      chk("abort_nodone", done, 0);
      chk("abort_busy2", busy, 0);
      ref_out = '0; ref_sout = 1'b0;
      do_op(16'h00F0, 2'b10, 2, 0);
      chk("post_abort", out, 16'h03C0);

      for (int i = 0; i < 40; i++) begin
         do_op(N'($urandom), 2'($urandom), int'($urandom_range(0, 2 ** AW - 1)), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_seq_reg.md
SHIFT_SEQ_REG -- requirements
Module: shift_seq_reg

Interface
REQ-001 Parameter: N, 16, register width in bits (N >= 2).
REQ-002 Derived constant: AW, clog2(N)+1, width of the shift-amount port; not user-overridable.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 ld  input  1  parallel-load request.
REQ-006 in  input  N  parallel-load data; bit 0 is LSB, bit N-1 is MSB.
REQ-007 start  input  1  shift-operation request.
REQ-008 amt  input  AW  number of single-bit shift steps; captured at start.
REQ-009 mode  input  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right; captured at start.
REQ-010 sin  input  1  serial fill bit for modes 00/10; sampled live on every shift step.
REQ-011 out  output  N  register contents (registered).
REQ-012 sout  output  1  last bit shifted out (registered).
REQ-013 busy  output  1  high while in SHIFT.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, DONE. Outputs are registered or decoded from state; no combinational input-to-output path.
REQ-016 In IDLE with ld=1, out SHALL take in at the next edge; start in the same cycle SHALL be ignored (ld wins).
REQ-017 In IDLE with start=1 and ld=0, the block SHALL capture amt and mode and go to SHIFT, or go directly to DONE if amt=0.
REQ-018 In SHIFT, each edge SHALL perform exactly one step per the captured mode and decrement the step counter; the step that brings the counter to zero SHALL also move the FSM to DONE.
REQ-019 Mode 00: out <= {sin, out[N-1:1]}. Mode 01: out <= {out[N-1], out[N-1:1]}. Mode 10: out <= {out[N-2:0], sin}. Mode 11: out <= {out[0], out[N-1:1]}.
REQ-020 On each step, sout SHALL take the exiting bit: out[0] for modes 00, 01 and 11; out[N-1] for mode 10. sout SHALL hold otherwise.
REQ-021 Latency: with start sampled at edge k and amt = A > 0, shifts SHALL occur at edges k+1..k+A. busy SHALL be high after edges k..k+A-1. done SHALL be high for exactly the cycle after edge k+A, with the final out valid in that cycle.
REQ-022 With amt=0, done SHALL pulse in the cycle after edge k, busy SHALL stay low, and out and sout SHALL be unchanged.
REQ-023 Amounts of N or more SHALL be honoured step by step without clamping: logical modes give all-fill, mode 01 gives all-sign, and mode 11 with amt=N restores the original value.
REQ-024 ld and start SHALL be ignored in SHIFT and DONE. DONE SHALL always return to IDLE at the next edge.
REQ-025 Changes to in, amt or mode while busy SHALL NOT affect the operation in progress.

Reset
REQ-026 clr=1 at an edge SHALL force out=0, sout=0, busy=0, done=0, counter=0, state IDLE, overriding all other inputs.
REQ-027 clr during SHIFT or DONE SHALL abort the operation with no done pulse.

Structure
REQ-028 Mode encodings (00/01/10/11) and FSM state encodings SHALL be placed in the shared package shift_pkg.
REQ-029 Each bit SHALL be an instance of a sub-module sr_cell (select among hold/load/from-left/from-right, flop with sync clr), generated N times. Edge fill and the mode-to-select decode SHALL live in shift_seq_reg.

Verification (N=16)
REQ-030 clr, then ld=1 with in=16'hA5C3 -> out=16'hA5C3 next cycle; busy=0; done=0.
REQ-031 Load 16'h8001, start with mode=01, amt=4 -> busy for 4 cycles, then done pulse with out=16'hF800 and sout=0.
REQ-032 Load 16'h0001, start with mode=10, sin=1, amt=3 -> out=16'h0003, 16'h0007, 16'h000F on successive steps; done after the third step; sout=0.
REQ-033 Load 16'h1234, start with mode=11, amt=16 -> 16 busy cycles, then done with out=16'h1234 and sout=0.
REQ-034 start with amt=0 -> done in the next cycle, busy never high, out unchanged; ld and start asserted together in IDLE -> load only, no done.
REQ-035 clr asserted in the second SHIFT cycle -> out=0, busy=0 next cycle, no done pulse; a subsequent ld and start operate normally.
